// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: round-robin share of the mist_io SD sector channel between two requesters.
// Optional SD_TIMEOUT_EN adds a transfer watchdog that aborts with an err pulse.
module sd_sector_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd10000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] req0_lba,
    input  logic        req0_rd,
    input  logic        req0_wr,
    output logic        req0_busy,
    output logic        req0_done,
    output logic        req0_err,
    output logic        req0_buff_wr,
    input  logic [7:0]  req0_buff_din,
    input  logic [31:0] req1_lba,
    input  logic        req1_rd,
    input  logic        req1_wr,
    output logic        req1_busy,
    output logic        req1_done,
    output logic        req1_err,
    output logic        req1_buff_wr,
    input  logic [7:0]  req1_buff_din,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic        owner
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t state;
    logic   ack_m, ack_s;
    logic   last_grant, op_rd, done_r, err_r;
    logic   pend0, pend1, gnt, can_grant, abort, active;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= sd_ack;
            ack_s <= ack_m;
        end
    end

    assign pend0  = req0_rd | req0_wr;
    assign pend1  = req1_rd | req1_wr;
    assign gnt    = (pend0 & pend1) ? ~last_grant : pend1;
    assign active = (state == REQ) | (state == XFER);

`ifdef SD_TIMEOUT_EN
    logic [23:0] cnt;
    always_ff @(posedge clk_sys) begin
        if (reset | ~active)
            cnt <= 24'd0;
        else
            cnt <= cnt + 24'd1;
    end
    assign abort     = active & (cnt == TIMEOUT - 24'd1);
    // a late ack from an aborted sector must drain before the next grant
    assign can_grant = (pend0 | pend1) & ~ack_s;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign abort          = 1'b0;
    assign can_grant      = pend0 | pend1;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            sd_lba     <= 32'd0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_rd      <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: if (can_grant) begin
                    owner      <= gnt;
                    last_grant <= gnt;
                    sd_lba     <= gnt ? req1_lba : req0_lba;
                    op_rd      <= gnt ? req1_rd : req0_rd;
                    state      <= REQ;
                end
                REQ: if (abort) begin
                    sd_rd  <= 1'b0;
                    sd_wr  <= 1'b0;
                    done_r <= 1'b1;
                    err_r  <= 1'b1;
                    state  <= DONE;
                end else if (ack_s) begin
                    sd_rd <= 1'b0;
                    sd_wr <= 1'b0;
                    state <= XFER;
                end else begin
                    sd_rd <= op_rd;
                    sd_wr <= ~op_rd;
                end
                XFER: if (abort) begin
                    done_r <= 1'b1;
                    err_r  <= 1'b1;
                    state  <= DONE;
                end else if (!ack_s) begin
                    done_r <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req0_busy    = (state != IDLE) & ~owner;
    assign req1_busy    = (state != IDLE) & owner;
    assign req0_done    = done_r & ~owner;
    assign req1_done    = done_r & owner;
    assign req0_err     = err_r & ~owner;
    assign req1_err     = err_r & owner;
    assign req0_buff_wr = sd_buff_wr & active & ~owner;
    assign req1_buff_wr = sd_buff_wr & active & owner;
    assign sd_buff_din  = owner ? req1_buff_din : req0_buff_din;
endmodule
